// File: rtl/i2c_sensor_responder_pkg.sv
// Shared I2C definitions: responder state encoding and the
// filtered-line event bundle produced by i2c_line_filter.
package i2c_sensor_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX_BYTE,
        TX_ACK,
        RX_BYTE,
        RX_ACK,
        IGNORE
    } state_t;

    typedef struct packed {
        logic scl;
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } line_ev_t;

endpackage

// File: rtl/i2c_sensor_responder_line_filter.sv
// SCL/SDA synchronizer plus majority-free glitch filter; a new level is
// accepted only after FILT_LEN identical samples. Emits edge/START/STOP flags.
module i2c_line_filter
    import i2c_sensor_responder_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     scl_raw,
    input  logic     sda_raw,
    output line_ev_t ev
);

    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-1:0] scl_hist, sda_hist;
    logic                scl_lvl, sda_lvl;
    logic                scl_q, sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_lvl  <= 1'b1;
            sda_lvl  <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_raw};
            sda_sync <= {sda_sync[0], sda_raw};
            scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
            if (&scl_hist)
                scl_lvl <= 1'b1;
            else if (~|scl_hist)
                scl_lvl <= 1'b0;
            if (&sda_hist)
                sda_lvl <= 1'b1;
            else if (~|sda_hist)
                sda_lvl <= 1'b0;
            scl_q <= scl_lvl;
            sda_q <= sda_lvl;
        end
    end

    // START/STOP need SCL stable high across the SDA transition
    always_comb begin
        ev.scl      = scl_lvl;
        ev.sda      = sda_lvl;
        ev.scl_rise = scl_lvl & ~scl_q;
        ev.scl_fall = ~scl_lvl & scl_q;
        ev.start    = scl_lvl & scl_q & sda_q & ~sda_lvl;
        ev.stop     = scl_lvl & scl_q & ~sda_q & sda_lvl;
    end

endmodule

// File: rtl/i2c_sensor_responder.sv
// I2C target emulating CHN byte-wide sensors: reads return value_in,
// writes are strobed out on wr_data/wr_valid.
module i2c_sensor_responder
    import i2c_sensor_responder_pkg::*;
#(
    parameter int                     SYS_FREQ    = 100_000_000,
    parameter int                     CHN         = 2,
    parameter int                     CHN_BIT_WID = 1,
    parameter logic [6-CHN_BIT_WID:0] HEAD_ADDR   = 6'b100100,
    parameter int                     FILT_LEN    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CHN*8-1:0]       value_in,
    output logic [CHN-1:0]         rd_done,
    output logic [7:0]             wr_data,
    output logic                   wr_valid,
    output logic [CHN_BIT_WID-1:0] wr_chn,
    output logic                   busy,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   scl_out,
    output logic                   sda_out
);

    line_ev_t ev;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk     (clk),
        .rst     (rst),
        .scl_raw (scl_in),
        .sda_raw (sda_in),
        .ev      (ev)
    );

    state_t                 state, state_nx;
    logic [2:0]             cnt, cnt_nx;
    logic [7:0]             shreg, shreg_nx;
    logic [7:0]             tx, tx_nx;
    logic [CHN_BIT_WID-1:0] chn, chn_nx;
    logic                   rw, rw_nx;
    logic                   sda_nx, busy_nx, wr_valid_nx;
    logic [CHN-1:0]         rd_done_nx;
    logic [7:0]             wr_data_nx;
    logic [CHN_BIT_WID-1:0] wr_chn_nx;

    logic [7:0]             rx_byte;
    logic [CHN_BIT_WID-1:0] rx_chn;
    logic                   addr_hit;
    logic [7:0]             snap;

    assign scl_out  = 1'b1;
    assign rx_byte  = {shreg[6:0], ev.sda};
    assign rx_chn   = rx_byte[CHN_BIT_WID:1];
    assign addr_hit = (rx_byte[7:1+CHN_BIT_WID] == HEAD_ADDR)
                   && (int'(rx_chn) < CHN);
    assign snap     = value_in[int'(chn)*8 +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            tx       <= '1;
            chn      <= '0;
            rw       <= 1'b0;
            sda_out  <= 1'b1;
            busy     <= 1'b0;
            rd_done  <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_chn   <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            shreg    <= shreg_nx;
            tx       <= tx_nx;
            chn      <= chn_nx;
            rw       <= rw_nx;
            sda_out  <= sda_nx;
            busy     <= busy_nx;
            rd_done  <= rd_done_nx;
            wr_valid <= wr_valid_nx;
            wr_data  <= wr_data_nx;
            wr_chn   <= wr_chn_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        shreg_nx    = shreg;
        tx_nx       = tx;
        chn_nx      = chn;
        rw_nx       = rw;
        sda_nx      = sda_out;
        busy_nx     = busy;
        rd_done_nx  = '0;
        wr_valid_nx = 1'b0;
        wr_data_nx  = wr_data;
        wr_chn_nx   = wr_chn;

        // STOP outranks START and any coincident SCL edge
        if (ev.stop) begin
            state_nx = IDLE;
            sda_nx   = 1'b1;
            busy_nx  = 1'b0;
        end else if (ev.start) begin
            state_nx = ADDR;
            cnt_nx   = '0;
            sda_nx   = 1'b1;
            busy_nx  = 1'b1;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: if (ev.scl_rise) begin
                    shreg_nx = rx_byte;
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (addr_hit) begin
                            state_nx = ADDR_ACK;
                            chn_nx   = rx_chn;
                            rw_nx    = rx_byte[0];
                            tx_nx    = value_in[int'(rx_chn)*8 +: 8];
                            if (!rx_byte[0])
                                wr_chn_nx = rx_chn;
                        end else begin
                            state_nx = IGNORE;
                            busy_nx  = 1'b0;
                        end
                    end
                end
                // sda_out marks the ACK phase: 1 = waiting, 0 = driving
                ADDR_ACK: if (ev.scl_fall) begin
                    if (sda_out) begin
                        sda_nx = 1'b0;
                    end else if (rw) begin
                        state_nx = TX_BYTE;
                        sda_nx   = tx[7];
                        tx_nx    = {tx[6:0], 1'b1};
                        cnt_nx   = '0;
                    end else begin
                        state_nx = RX_BYTE;
                        sda_nx   = 1'b1;
                        cnt_nx   = '0;
                    end
                end
                TX_BYTE: if (ev.scl_fall) begin
                    if (cnt == 3'd7) begin
                        state_nx = TX_ACK;
                        sda_nx   = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        sda_nx = tx[7];
                        tx_nx  = {tx[6:0], 1'b1};
                        cnt_nx = cnt + 3'd1;
                    end
                end
                TX_ACK: begin
                    if (ev.scl_rise) begin
                        cnt_nx          = 3'd1;
                        shreg_nx[0]     = ev.sda;
                        rd_done_nx[chn] = 1'b1;
                    end else if (ev.scl_fall && cnt == 3'd1) begin
                        if (!shreg[0]) begin
                            state_nx = TX_BYTE;
                            sda_nx   = snap[7];
                            tx_nx    = {snap[6:0], 1'b1};
                            cnt_nx   = '0;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                RX_BYTE: if (ev.scl_rise) begin
                    shreg_nx = rx_byte;
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_nx    = RX_ACK;
                        wr_data_nx  = rx_byte;
                        wr_valid_nx = 1'b1;
                    end
                end
                RX_ACK: if (ev.scl_fall) begin
                    if (sda_out) begin
                        sda_nx = 1'b0;
                    end else begin
                        state_nx = RX_BYTE;
                        sda_nx   = 1'b1;
                        cnt_nx   = '0;
                    end
                end
                IGNORE: sda_nx = 1'b1;
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Directed and randomized I2C master transactions against a
// transaction-level model of the sensor responder.
module tb_i2c_sensor_responder;

    localparam int Q = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic [1:0]  rd_done;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic [0:0]  wr_chn;
    logic        busy;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_out, sda_out;
    logic        sda_bus;

    int vectors = 0;
    int miscompares = 0;
    int rd_cnt [2];
    logic [7:0] wr_q [$];
    logic       wr_chn_q [$];

    assign sda_bus = sda_m & sda_out;

    i2c_sensor_responder dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .rd_done  (rd_done),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_chn   (wr_chn),
        .busy     (busy),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .scl_out  (scl_out),
        .sda_out  (sda_out)
    );

    always #5 clk = ~clk;

    initial begin
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++)
                if (rd_done[c]) rd_cnt[c] = rd_cnt[c] + 1;
            if (wr_valid) begin
                wr_q.push_back(wr_data);
                wr_chn_q.push_back(wr_chn[0]);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack,
                             input logic chg, input logic [7:0] nv);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
            if (chg && i == 4) value_in[7:0] = nv;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [6:0] addr;
        logic       rd;
        int         nb, r0, r1, ch;
        logic [7:0] exp_q [$];

        tick(3);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_scl_out", scl_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_done", rd_done, 2'b00);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_wr_chn", wr_chn, 1'b0);
        rst = 1'b0;
        tick(10);

        // Read channel 1, single byte with NACK
        value_in = {8'hA5, 8'h3C};
        bus_start();
        write_byte({7'h49, 1'b1}, ack);
        check("rd49_ack", ack, 1'b0);
        check("rd49_busy", busy, 1'b1);
        read_byte(d, 1'b1, 1'b0, 8'h00);
        check("rd49_data", d, 8'hA5);
        bus_stop();
        check("rd49_done1", rd_cnt[1], 1);
        check("rd49_done0", rd_cnt[0], 0);
        check("rd49_idle_busy", busy, 1'b0);
        check("rd49_idle_sda", sda_out, 1'b1);

        // Two-byte read with value change mid byte 1
        value_in = {8'h00, 8'h11};
        bus_start();
        write_byte({7'h48, 1'b1}, ack);
        check("rd48_ack", ack, 1'b0);
        read_byte(d, 1'b0, 1'b1, 8'h22);
        check("rd48_b1", d, 8'h11);
        read_byte(d, 1'b1, 1'b0, 8'h00);
        check("rd48_b2", d, 8'h22);
        bus_stop();
        check("rd48_done0", rd_cnt[0], 2);
        check("rd48_done1", rd_cnt[1], 1);

        // Write two bytes to channel 0
        wr_q.delete(); wr_chn_q.delete();
        bus_start();
        write_byte({7'h48, 1'b0}, ack);
        check("wr_addr_ack", ack, 1'b0);
        write_byte(8'h5A, ack);
        check("wr_b1_ack", ack, 1'b0);
        write_byte(8'hC3, ack);
        check("wr_b2_ack", ack, 1'b0);
        bus_stop();
        check("wr_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("wr_d1", wr_q[0], 8'h5A);
            check("wr_d2", wr_q[1], 8'hC3);
            check("wr_chn", wr_chn_q[1], 1'b0);
        end

        // Foreign address: no ACK, not busy, no strobes
        wr_q.delete();
        r0 = rd_cnt[0]; r1 = rd_cnt[1];
        bus_start();
        write_byte({7'h50, 1'b1}, ack);
        check("nomatch_ack", ack, 1'b1);
        check("nomatch_busy", busy, 1'b0);
        bus_stop();
        check("nomatch_rd", rd_cnt[0] + rd_cnt[1], r0 + r1);
        check("nomatch_wr", wr_q.size(), 0);

        // Glitches: idle SDA dip, then SDA spike inside a data bit
        sda_m = 1'b0; tick(1); sda_m = 1'b1;
        tick(4*Q);
        check("glitch_start_busy", busy, 1'b0);
        wr_q.delete();
        bus_start();
        write_byte({7'h48, 1'b0}, ack);
        check("glitch_addr_ack", ack, 1'b0);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(1); sda_m = 1'b0;
        tick(Q);
        check("glitch_stop_busy", busy, 1'b1);
        scl_m = 1'b0; tick(Q);
        d = 8'h35;
        for (int i = 6; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
        check("glitch_b_ack", ack, 1'b0);
        bus_stop();
        check("glitch_wr_cnt", wr_q.size(), 1);
        if (wr_q.size() == 1) check("glitch_wr_data", wr_q[0], 8'h35);

        // Reset while the responder drives a 0 data bit
        value_in = 16'h0000;
        bus_start();
        write_byte({7'h48, 1'b1}, ack);
        check("rstmid_ack", ack, 1'b0);
        check("rstmid_drive0", sda_out, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid_release", sda_out, 1'b1);
        tick(3);
        rst = 1'b0;
        tick(4);
        value_in = 16'h006E;
        r0 = rd_cnt[0];
        bus_start();
        write_byte({7'h48, 1'b1}, ack);
        check("rstpost_ack", ack, 1'b0);
        read_byte(d, 1'b1, 1'b0, 8'h00);
        check("rstpost_data", d, 8'h6E);
        bus_stop();
        check("rstpost_done", rd_cnt[0], r0 + 1);

        // Randomized transactions against the transaction model
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0: addr = 7'h48;
                1: addr = 7'h49;
                default: addr = 7'($urandom_range(0, 127));
            endcase
            rd = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            value_in = 16'($urandom);
            ch = int'(addr[0]);
            r0 = rd_cnt[0]; r1 = rd_cnt[1];
            wr_q.delete(); wr_chn_q.delete(); exp_q.delete();
            bus_start();
            write_byte({addr, rd}, ack);
            check("rnd_addr_ack", ack, (addr[6:1] == 6'b100100) ? 1'b0 : 1'b1);
            if (addr[6:1] == 6'b100100) begin
                for (int b = 0; b < nb; b++) begin
                    if (rd) begin
                        read_byte(d, (b == nb-1), 1'b0, 8'h00);
                        check("rnd_rd_data", d, value_in[ch*8 +: 8]);
                    end else begin
                        d = 8'($urandom);
                        exp_q.push_back(d);
                        write_byte(d, ack);
                        check("rnd_wr_ack", ack, 1'b0);
                    end
                end
            end else begin
                check("rnd_nomatch_busy", busy, 1'b0);
            end
            bus_stop();
            check("rnd_idle_busy", busy, 1'b0);
            if (rd && addr[6:1] == 6'b100100) begin
                check("rnd_rd_cnt0", rd_cnt[0] - r0, ch == 0 ? nb : 0);
                check("rnd_rd_cnt1", rd_cnt[1] - r1, ch == 1 ? nb : 0);
            end else begin
                check("rnd_no_rd", (rd_cnt[0] - r0) + (rd_cnt[1] - r1), 0);
            end
            check("rnd_wr_cnt", wr_q.size(), exp_q.size());
            if (wr_q.size() == exp_q.size())
                for (int k = 0; k < exp_q.size(); k++) begin
                    check("rnd_wr_data", wr_q[k], exp_q[k]);
                    check("rnd_wr_chn", wr_chn_q[k], addr[0]);
                end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_sensor_responder.md
I2C_SENSOR_RESPONDER -- requirements
Module: i2c_sensor_responder

Interface
REQ-001 Parameter SYS_FREQ, 100_000_000, system clock frequency in Hz (documentation only; no timing derived).
REQ-002 Parameter CHN, 2, number of emulated sensor channels.
REQ-003 Parameter CHN_BIT_WID, 1, channel-select bits in the low part of the 7-bit address.
REQ-004 Parameter HEAD_ADDR, 6'b100100, upper 7-CHN_BIT_WID address bits.
REQ-005 Parameter FILT_LEN, 3, consecutive equal samples required to accept a new SCL/SDA level.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high; ports are clk (in, 1) and rst (in, 1).
REQ-007 value_in  in  CHN*8  per-channel byte returned on reads; channel n occupies bits [n*8+:8].
REQ-008 rd_done  out  CHN  one-cycle pulse on bit n when a byte from channel n finishes its master ACK/NACK bit.
REQ-009 wr_data  out  8  last byte written by the master; valid while wr_valid is high.
REQ-010 wr_valid  out  1  one-cycle pulse per received write byte.
REQ-011 wr_chn  out  CHN_BIT_WID  channel addressed by the write in progress.
REQ-012 busy  out  1  high from an accepted address through STOP.
REQ-013 scl_in, sda_in  in  1  raw bus levels.
REQ-014 scl_out  out  1  constant 1; no clock stretching.
REQ-015 sda_out  out  1  open-drain drive value: 0 pulls low, 1 releases.

Function
REQ-016 SCL and SDA SHALL pass through a 2-flop synchronizer, then a FILT_LEN-sample glitch filter; all decoding uses the filtered levels.
REQ-017 START SHALL be a filtered SDA 1->0 while SCL=1; STOP SHALL be SDA 0->1 while SCL=1; both SHALL be detected in every state.
REQ-018 States: IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, IGNORE.
REQ-019 START in any state -> ADDR with the bit counter cleared (repeated START supported); STOP in any state -> IDLE, sda_out=1, busy=0.
REQ-020 In ADDR and RX_BYTE, SDA SHALL be sampled on each SCL rising edge, MSB first; a 3-bit counter ends the byte at 8 bits.
REQ-021 Address match: bits[7:1+CHN_BIT_WID]==HEAD_ADDR and channel field < CHN; a match -> ADDR_ACK and the channel is latched; a mismatch -> IGNORE with sda_out=1.
REQ-022 ADDR_ACK: sda_out=0 from the SCL falling edge after bit 8 to the next SCL falling edge.
REQ-023 Read address (R/W=1): value_in byte of the latched channel SHALL be snapshotted at the ADDR_ACK entry; then -> TX_BYTE.
REQ-024 TX_BYTE: sda_out SHALL change only on SCL falling edges, driving the snapshot MSB first; after 8 bits SDA is released -> TX_ACK.
REQ-025 TX_ACK: the master bit is sampled on SCL rising, and rd_done[chn] pulses; ACK(0) re-snapshots value_in and -> TX_BYTE at SCL falling; NACK(1) -> IGNORE.
REQ-026 Write address (R/W=0): -> RX_BYTE; on the 8th SCL rising, wr_data updates and wr_valid pulses once; -> RX_ACK, which drives 0 for one SCL period and then -> RX_BYTE.
REQ-027 IGNORE: sda_out=1 until START or STOP.
REQ-028 busy=1 in every state except IDLE and IGNORE-after-mismatch.
REQ-029 Simultaneous STOP and SCL edge in the same cycle: STOP SHALL win.

Reset
REQ-030 rst SHALL immediately force: state IDLE, sda_out=1, scl_out=1, rd_done=0, wr_valid=0, wr_data=0, wr_chn=0, busy=0, filters to 1 (idle bus).
REQ-031 Reset asserted mid-transfer SHALL release SDA in the same cycle; after deassertion the block SHALL ignore bus activity until the next START.

Structure
REQ-032 State encodings and the START/STOP detector outputs SHALL live in a shared package/include used with the existing I2C master.
REQ-033 One sub-module, i2c_line_filter (synchronizer + FILT_LEN glitch filter + edge/START/STOP flags), instantiated once for SCL/SDA.

Verification
REQ-034 Master reads addr 0x49, value_in={8'hA5,8'h3C} -> slave ACKs, returns 0xA5, master NACK -> rd_done=2'b10 pulse, IDLE after STOP.
REQ-035 Master reads addr 0x48, 2 bytes, ACK then NACK, value_in[7:0] changed 0x11->0x22 during byte 1 -> bytes 0x11 then 0x22, two rd_done[0] pulses.
REQ-036 Master writes 0x48 then 0x5A, 0xC3 -> both ACKed, wr_valid pulses twice with wr_data 0x5A then 0xC3, wr_chn=0.
REQ-037 Address 0x50 -> no ACK (SDA stays 1), busy=0, no strobes.
REQ-038 1-cycle SDA glitch while SCL=1 -> no START/STOP detected; FILT_LEN=3.
REQ-039 rst asserted in TX_BYTE while driving 0 -> sda_out=1 same cycle; a fresh read of 0x48 after release completes normally.
